// File: rtl/sa_filter.sv
// Loadable destination-address filter: a 128-byte setup frame fills a 14-entry address
// table, then the first six bytes of every received frame are compared against it.
module sa_filter #(
  parameter int NADDR     = 14,
  parameter int SETUP_LEN = 128,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld_start,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_busy,
  output logic              o_ld_done,
  input  logic              i_rx_start,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_promisc,
  input  logic              i_allmc,
  output logic              o_match_vld,
  output logic              o_match
);

  localparam logic [6:0] LD_LAST = 7'(SETUP_LEN - 1);
  localparam logic [2:0] DA_LAST = 3'd5;

  typedef enum logic {LD_IDLE, LD_RUN} ld_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_DA, RX_SKIP} rx_state_t;

  ld_state_t r_ld_state, w_ld_next;
  rx_state_t r_rx_state, w_rx_next;

  logic [6:0]       r_cnt, w_cnt_next;
  logic [NADDR-1:0] r_valid, w_valid_next;
  logic             r_ld_done;
  logic [DATA_W-1:0] r_tab [NADDR][6];

  logic       w_ld_take, w_ld_last, w_wr_en;
  logic [6:0] w_off;
  logic [2:0] w_row, w_col;
  logic [3:0] w_entry;

  logic [2:0]       r_idx, w_idx, w_idx_next;
  logic [NADDR-1:0] r_hit, w_hit_base, w_hit_next, w_cmp;
  logic             r_mc, w_mc_next;
  logic             r_match_vld, r_match;
  logic             w_rx_take, w_rx_last, w_decision;

  // ---- setup-frame load: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_state <= LD_IDLE;
      r_cnt      <= '0;
      r_valid    <= '0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_state <= w_ld_next;
      r_cnt      <= w_cnt_next;
      r_valid    <= w_valid_next;
      r_ld_done  <= w_ld_last;
    end
  end

  // A byte arriving with ld_start is byte 0 of the new load, so the offset is forced to 0.
  always_comb begin
    w_ld_next    = r_ld_state;
    w_ld_take    = 1'b0;
    w_off        = r_cnt;
    w_cnt_next   = r_cnt;
    w_valid_next = r_valid;
    if (i_ld_start) begin
      w_ld_next    = LD_RUN;
      w_off        = '0;
      w_ld_take    = i_ld_valid;
      w_cnt_next   = '0;
      w_valid_next = '0;
    end else if (r_ld_state == LD_RUN) begin
      w_ld_take = i_ld_valid;
    end
    w_row   = w_off[5:3];
    w_col   = w_off[2:0];
    w_entry = (w_off[6] ? 4'd7 : 4'd0) + {1'b0, w_col} - 4'd1;
    w_wr_en = w_ld_take && (w_col != 3'd0) && (w_row < 3'd6);
    w_ld_last = w_ld_take && (w_off == LD_LAST);
    if (w_ld_take && (w_off != 7'h7F)) w_cnt_next = w_off + 7'd1;
    if (w_wr_en && (w_row == DA_LAST)) w_valid_next[w_entry] = 1'b1;
    if (w_ld_last) w_ld_next = LD_IDLE;
    o_ld_busy = (r_ld_state == LD_RUN);
    o_ld_done = r_ld_done;
  end

  // Table contents are data only; validity is tracked separately in r_valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_tab[w_entry][w_row] <= i_ld_data;
  end

  // ---- receive-side DA compare: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state  <= RX_IDLE;
      r_idx       <= '0;
      r_match_vld <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_next;
      r_idx       <= w_idx_next;
      r_match_vld <= w_rx_last;
      r_match     <= w_rx_last & w_decision;
    end
  end

  always_ff @(posedge clk) begin
    r_hit <= w_hit_next;
    r_mc  <= w_mc_next;
  end

  always_comb begin
    w_rx_next  = r_rx_state;
    w_rx_take  = 1'b0;
    w_idx      = r_idx;
    w_hit_base = r_hit;
    if (i_rx_start) begin
      w_rx_next  = RX_DA;
      w_rx_take  = i_rx_valid;
      w_idx      = '0;
      w_hit_base = r_valid;
    end else if (r_rx_state == RX_DA) begin
      w_rx_take = i_rx_valid;
    end
    for (int e = 0; e < NADDR; e++) begin
      w_cmp[e] = (r_tab[e][w_idx] == i_rx_data);
    end
    w_hit_next = w_rx_take ? (w_hit_base & w_cmp) : w_hit_base;
    w_mc_next  = (w_rx_take && (w_idx == 3'd0)) ? i_rx_data[0] : r_mc;
    w_rx_last  = w_rx_take && (w_idx == DA_LAST);
    w_idx_next = w_rx_take ? (w_idx + 3'd1) : w_idx;
    if (w_rx_last) begin
      w_rx_next  = RX_SKIP;
      w_idx_next = '0;
    end
    w_decision  = (|w_hit_next) | i_promisc | (i_allmc & w_mc_next);
    o_match_vld = r_match_vld;
    o_match     = r_match;
  end

endmodule

// File: tb/tb_sa_filter.sv
// Directed bench for sa_filter: stimulus pushes expected decisions into a queue,
// a monitor pops them whenever match_vld is seen.
module tb_sa_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_ld_start = 1'b0, i_ld_valid = 1'b0;
  logic [7:0] i_ld_data = '0;
  logic       i_rx_start = 1'b0, i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = '0;
  logic       i_promisc = 1'b0, i_allmc = 1'b0;
  logic       o_ld_busy, o_ld_done, o_match_vld, o_match;

  sa_filter dut (
    .clk(clk), .rst_n(rst_n),
    .i_ld_start(i_ld_start), .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data),
    .o_ld_busy(o_ld_busy), .o_ld_done(o_ld_done),
    .i_rx_start(i_rx_start), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .i_promisc(i_promisc), .i_allmc(i_allmc),
    .o_match_vld(o_match_vld), .o_match(o_match)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { bit m; int t; } exp_t;
  exp_t q[$];
  int n_vec = 0, n_bad = 0, n_done = 0;
  logic [7:0] img [128];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every decision must match the oldest queued expectation, in value and cycle.
  always @(negedge clk) begin
    if (rst_n && o_ld_done) n_done++;
    if (rst_n && o_match_vld) begin
      if (q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_match_vld: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("match", {31'd0, o_match}, {31'd0, e.m});
        check("latency", cyc, e.t);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_img();
    foreach (img[i]) img[i] = 8'h00;
  endtask

  task automatic put_entry(input int e, input logic [47:0] a);
    int base;
    base = (e / 7) * 64 + (e % 7) + 1;
    for (int r = 0; r < 6; r++) img[base + r*8] = a[47 - 8*r -: 8];
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) check("ld_done_timing", {31'd0, o_ld_done}, {31'd0, (i-1) == 127});
      if (i == 64) check("ld_busy_mid", {31'd0, o_ld_busy}, 32'd1);
      i_ld_start = (i == 0);
      i_ld_valid = 1'b1;
      i_ld_data  = img[i % 128];
    end
    @(negedge clk);
    check("ld_done_timing", {31'd0, o_ld_done}, {31'd0, (n-1) == 127});
    i_ld_start = 1'b0;
    i_ld_valid = 1'b0;
  endtask

  task automatic part(input logic [47:0] da, input int n);
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      i_rx_start = (r == 0);
      i_rx_valid = 1'b1;
      i_rx_data  = da[47 - 8*r -: 8];
    end
  endtask

  task automatic frame(input logic [47:0] da, input bit exp, input bit pr, input bit am,
                       input int payload);
    exp_t e;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      if (r == 0) begin
        e.m = exp; e.t = cyc + 6;
        q.push_back(e);
      end
      i_rx_start = (r == 0);
      i_rx_valid = 1'b1;
      i_rx_data  = da[47 - 8*r -: 8];
      i_promisc  = pr;
      i_allmc    = am;
    end
    for (int p = 0; p < payload; p++) begin
      @(negedge clk);
      i_rx_start = 1'b0;
      i_rx_data  = 8'(p * 37 + 5);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_rx_start = 1'b0;
      i_rx_valid = 1'b0;
    end
  endtask

  localparam logic [47:0] DA0  = 48'hAA0004010203;
  localparam logic [47:0] DA0X = 48'hAA0004010204;
  localparam logic [47:0] DA13 = 48'h01005E000001;
  localparam logic [47:0] MCX  = 48'h01005E000002;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    check("rst_ld_busy", {31'd0, o_ld_busy}, 32'd0);
    check("rst_ld_done", {31'd0, o_ld_done}, 32'd0);
    check("rst_match_vld", {31'd0, o_match_vld}, 32'd0);
    check("rst_match", {31'd0, o_match}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    frame(DA0, 0, 0, 0, 0);          // empty table rejects everything
    idle(3);

    // Entries 0 and 13 loaded; entries 1..12 load as valid all-zero addresses.
    clear_img();
    put_entry(0, DA0);
    put_entry(13, DA13);
    d0 = n_done;
    load(128);
    idle(2);
    check("ld_done_count", n_done - d0, 32'd1);
    check("ld_busy_after", {31'd0, o_ld_busy}, 32'd0);

    frame(DA0, 1, 0, 0, 4);          // payload bytes in skip state are ignored
    frame(DA0X, 0, 0, 0, 0);
    frame(DA0X, 1, 1, 0, 0);
    frame(DA13, 1, 0, 0, 0);
    frame(MCX, 1, 0, 1, 0);
    frame(MCX, 0, 0, 0, 0);
    frame(BC, 0, 0, 0, 0);           // no implicit broadcast acceptance
    frame(48'h0, 1, 0, 0, 0);
    idle(3);
    part(DA0, 3);                    // aborted frame gives no decision
    frame(MCX, 0, 0, 0, 0);
    // Back-to-back frames, no idle cycles between them.
    frame(DA0, 1, 0, 0, 0);
    frame(DA0X, 0, 0, 0, 0);
    frame(DA13, 1, 0, 0, 0);
    idle(4);

    // Restart after 40 bytes, then reload without entry 0, with 2 surplus bytes.
    load(40);
    clear_img();
    put_entry(13, DA13);
    d0 = n_done;
    load(130);
    idle(3);
    check("ld_done_count_130", n_done - d0, 32'd1);
    frame(DA0, 0, 0, 0, 0);
    frame(DA13, 1, 0, 0, 0);
    idle(3);

    // Reset in the middle of a DA: no decision, table invalidated.
    part(DA13, 3);
    @(negedge clk);
    rst_n = 1'b0;
    i_rx_start = 1'b0; i_rx_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_match_vld", {31'd0, o_match_vld}, 32'd0);
    check("rst_mid_ld_busy", {31'd0, o_ld_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    frame(DA13, 0, 0, 0, 0);
    frame(48'h0, 0, 0, 0, 0);
    idle(10);
    check("queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
